execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_pkg.sv | 46 ++++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/execute_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, forwarding selects,
// datapath widths, EX/MEM payload structs and the multiplier FSM state encoding.
package execute_stage_pkg;

  localparam int unsigned DataWidth = 19;
  localparam int unsigned RegWidth  = 5;

  localparam logic [1:0] FwdReg     = 2'b00;
  localparam logic [1:0] FwdResultW = 2'b01;
  localparam logic [1:0] FwdAluM    = 2'b10;

  localparam logic [4:0] MulLastIter = 5'(DataWidth - 1);

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6,
    AluSlt = 4'd7,
    AluMul = 4'd8
  } aluOp_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } mulState_e;

  typedef struct packed {
    logic                 regWrite;
    logic                 memWrite;
    logic                 resultSrc;
    logic                 cantByte;
    logic [RegWidth-1:0]  rd;
    logic [DataWidth-1:0] writeData;
  } exCtrl_t;

  typedef struct packed {
    exCtrl_t              ctrl;
    logic [DataWidth-1:0] aluResult;
  } exMem_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, lower DataWidth bits
// kept. Latches operands and the instruction's control so upstream may change while busy.
module alu_mul_seq
  import execute_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DataWidth-1:0] opA,
  input  logic [DataWidth-1:0] opB,
  input  exCtrl_t              ctrlIn,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] product,
  output exCtrl_t              ctrlOut
);

  mulState_e            stateQ, stateD;
  logic [4:0]           iterQ;
  logic [DataWidth-1:0] accQ, mcandQ, mplierQ;
  exCtrl_t              ctrlQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (start) stateD = StMul;
      StMul:   if (iterQ == MulLastIter) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    busy = ((stateQ == StIdle) && start) || (stateQ == StMul);
    done = (stateQ == StDone);
  end

  // Multiplicand walks left, multiplier walks right; bit 0 of the multiplier gates the add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iterQ   <= '0;
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      ctrlQ   <= '0;
    end else if ((stateQ == StIdle) && start) begin
      iterQ   <= '0;
      accQ    <= '0;
      mcandQ  <= opA;
      mplierQ <= opB;
      ctrlQ   <= ctrlIn;
    end else if (stateQ == StMul) begin
      if (mplierQ[0]) accQ <= accQ + mcandQ;
      mcandQ  <= mcandQ << 1;
      mplierQ <= mplierQ >> 1;
      iterQ   <= iterQ + 5'd1;
    end
  end

  assign product = accQ;
  assign ctrlOut = ctrlQ;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, combinational ALU and the EX/MEM pipeline register.
// Define EXECUTE_MUL_EN to build in the multi-cycle multiplier (alu_mul_seq).
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 ResultSrcE,
  input  logic                 Cant_ByteE,
  input  logic [3:0]           ALUControlE,
  input  logic                 ALUSrcE,
  input  logic [RegWidth-1:0]  RdE,
  input  logic [DataWidth-1:0] RD1E,
  input  logic [DataWidth-1:0] RD2E,
  input  logic [DataWidth-1:0] ImmExtE,
  input  logic [DataWidth-1:0] ResultW,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 ResultSrcM,
  output logic                 Cant_ByteM,
  output logic [RegWidth-1:0]  RDM,
  output logic [DataWidth-1:0] WriteDataM,
  output logic [DataWidth-1:0] ALUResultM,
  output logic                 BusyE
);

  logic [DataWidth-1:0] srcA, fwdB, srcB, aluResult;
  logic [4:0]           shamt;
  exCtrl_t              ctrlE;
  exMem_t               exMemQ, exMemD;

  logic                 mulBusy, mulDone;
  logic [DataWidth-1:0] mulProduct;
  exCtrl_t              mulCtrl;

  always_comb begin
    case (ForwardAE)
      FwdResultW: srcA = ResultW;
      FwdAluM:    srcA = ALUResultM;
      default:    srcA = RD1E;
    endcase
    case (ForwardBE)
      FwdResultW: fwdB = ResultW;
      FwdAluM:    fwdB = ALUResultM;
      default:    fwdB = RD2E;
    endcase
    srcB = ALUSrcE ? ImmExtE : fwdB;
  end

  assign shamt = srcB[4:0];

  always_comb begin
    aluResult = '0;
    case (aluOp_e'(ALUControlE))
      AluAdd: aluResult = srcA + srcB;
      AluSub: aluResult = srcA - srcB;
      AluAnd: aluResult = srcA & srcB;
      AluOr:  aluResult = srcA | srcB;
      AluXor: aluResult = srcA ^ srcB;
      AluSll: aluResult = (shamt >= 5'(DataWidth)) ? '0 : (srcA << shamt);
      AluSrl: aluResult = (shamt >= 5'(DataWidth)) ? '0 : (srcA >> shamt);
      AluSlt: aluResult = (srcA < srcB) ? DataWidth'(1) : '0;
      default: aluResult = '0;
    endcase
  end

  always_comb begin
    ctrlE.regWrite  = RegWriteE;
    ctrlE.memWrite  = MemWriteE;
    ctrlE.resultSrc = ResultSrcE;
    ctrlE.cantByte  = Cant_ByteE;
    ctrlE.rd        = RdE;
    ctrlE.writeData = fwdB;
  end

`ifdef EXECUTE_MUL_EN
  alu_mul_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (ValidE && (ALUControlE == AluMul)),
    .opA     (srcA),
    .opB     (srcB),
    .ctrlIn  (ctrlE),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProduct),
    .ctrlOut (mulCtrl)
  );
`else
  assign mulBusy    = 1'b0;
  assign mulDone    = 1'b0;
  assign mulProduct = '0;
  assign mulCtrl    = '0;
`endif

  assign BusyE = mulBusy;

  // A finishing multiply owns the register for one edge; busy cycles and invalid slots bubble.
  always_comb begin
    exMemD = '0;
    if (mulDone) begin
      exMemD.ctrl      = mulCtrl;
      exMemD.aluResult = mulProduct;
    end else if (!mulBusy && ValidE) begin
      exMemD.ctrl      = ctrlE;
      exMemD.aluResult = aluResult;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) exMemQ <= '0;
    else       exMemQ <= exMemD;
  end

  assign RegWriteM  = exMemQ.ctrl.regWrite;
  assign MemWriteM  = exMemQ.ctrl.memWrite;
  assign ResultSrcM = exMemQ.ctrl.resultSrc;
  assign Cant_ByteM = exMemQ.ctrl.cantByte;
  assign RDM        = exMemQ.ctrl.rd;
  assign WriteDataM = exMemQ.ctrl.writeData;
  assign ALUResultM = exMemQ.aluResult;

endmodule
